// File: rtl/motor_pwm_pkg.sv
// Shared types and constants for the dual H-bridge PWM driver.
package motor_pwm_pkg;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_FWD  = 2'd1,
    DIR_BWD  = 2'd2
  } dir_t;

  typedef enum logic [1:0] {
    CH_OFF  = 2'd0,
    CH_RUN  = 2'd1,
    CH_DEAD = 2'd2
  } ch_state_t;

  localparam logic [1:0] DUTY_25  = 2'b00;
  localparam logic [1:0] DUTY_50  = 2'b01;
  localparam logic [1:0] DUTY_75  = 2'b10;
  localparam logic [1:0] DUTY_100 = 2'b11;

  // Bridge polarity pins, MSB drives IN1/IN3 and LSB drives IN2/IN4.
  localparam logic [1:0] PINS_OFF = 2'b00;
  localparam logic [1:0] PINS_FWD = 2'b10;
  localparam logic [1:0] PINS_BWD = 2'b01;

  // A request with both bits set is invalid and is treated as no request.
  function automatic dir_t decode_dir(input logic fwd, input logic bwd);
    if (fwd && !bwd) return DIR_FWD;
    if (bwd && !fwd) return DIR_BWD;
    return DIR_NONE;
  endfunction

  function automatic logic [1:0] dir_pins(input dir_t d);
    case (d)
      DIR_FWD: return PINS_FWD;
      DIR_BWD: return PINS_BWD;
      default: return PINS_OFF;
    endcase
  endfunction

  // Number of quarter periods the enable stays high for a duty code.
  function automatic int duty_quarters(input logic [1:0] code);
    case (code)
      DUTY_25:  return 1;
      DUTY_50:  return 2;
      DUTY_75:  return 3;
      DUTY_100: return 4;
      default:  return 0;
    endcase
  endfunction

endpackage

// File: rtl/motor_pwm_driver_if.sv
// Command and bridge-pin bundle between the direction FSMs and the PWM driver.
interface motor_pwm_driver_if;

  logic [1:0] DutyCycleA;
  logic [1:0] DutyCycleB;
  logic       FWDA;
  logic       BWDA;
  logic       FWDB;
  logic       BWDB;
  logic       ENA;
  logic       ENB;
  logic       IN1;
  logic       IN2;
  logic       IN3;
  logic       IN4;
  logic       PeriodStart;
  logic       FaultA;
  logic       FaultB;

  modport master (
    output DutyCycleA, DutyCycleB, FWDA, BWDA, FWDB, BWDB,
    input  ENA, ENB, IN1, IN2, IN3, IN4, PeriodStart, FaultA, FaultB
  );

  modport slave (
    input  DutyCycleA, DutyCycleB, FWDA, BWDA, FWDB, BWDB,
    output ENA, ENB, IN1, IN2, IN3, IN4, PeriodStart, FaultA, FaultB
  );

endinterface

// File: rtl/motor_pwm_driver_channel.sv
// One motor channel: boundary latch, OFF/RUN/DEAD FSM, dead counter and PWM compare.
module pwm_channel
  import motor_pwm_pkg::*;
#(
  parameter int PERIOD_CYCLES = 1000,
  parameter int DEAD_PERIODS  = 2,
  parameter int CNT_W         = $clog2(PERIOD_CYCLES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] cnt,
  input  logic             boundary,
  input  logic [1:0]       duty_code,
  input  logic             fwd,
  input  logic             bwd,
  output logic             en,
  output logic [1:0]       pins,
  output logic             fault
);

  localparam int THR_W   = CNT_W + 1;
  localparam int QUARTER = PERIOD_CYCLES / 4;
  localparam int DW      = $clog2(DEAD_PERIODS + 1);

  ch_state_t        state, state_next;
  dir_t             dir, dir_next, latched;
  logic [1:0]       duty, duty_next;
  logic [DW-1:0]    dead_cnt, dead_next;
  logic             fault_next;
  logic             en_next;
  logic [1:0]       pins_next;
  logic [CNT_W-1:0] cnt_next;
  logic [THR_W-1:0] thr_next;

  // State and registered bridge outputs; reset drops everything to OFF at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= CH_OFF;
      dir      <= DIR_NONE;
      duty     <= DUTY_25;
      dead_cnt <= '0;
      en       <= 1'b0;
      pins     <= PINS_OFF;
      fault    <= 1'b0;
    end else begin
      state    <= state_next;
      dir      <= dir_next;
      duty     <= duty_next;
      dead_cnt <= dead_next;
      en       <= en_next;
      pins     <= pins_next;
      fault    <= fault_next;
    end
  end

  // Commands only move the FSM at a boundary; outputs are precomputed for the next cnt value.
  always_comb begin
    state_next = state;
    dir_next   = dir;
    duty_next  = duty;
    dead_next  = dead_cnt;
    fault_next = fault;
    latched    = decode_dir(fwd, bwd);

    if (boundary) begin
      duty_next  = duty_code;
      fault_next = fwd & bwd;
      case (state)
        CH_OFF: begin
          if (latched != DIR_NONE) begin
            state_next = CH_RUN;
            dir_next   = latched;
          end
        end
        CH_RUN: begin
          if (latched == DIR_NONE) begin
            state_next = CH_OFF;
            dir_next   = DIR_NONE;
          end else if (latched != dir) begin
            state_next = CH_DEAD;
            dir_next   = latched;
            dead_next  = DW'(DEAD_PERIODS);
          end
        end
        CH_DEAD: begin
          dir_next  = latched;
          dead_next = dead_cnt - 1'b1;
          if (dead_next == '0) begin
            if (latched == DIR_NONE) state_next = CH_OFF;
            else                     state_next = CH_RUN;
          end
        end
        default: begin
          state_next = CH_OFF;
          dir_next   = DIR_NONE;
        end
      endcase
    end

    cnt_next  = boundary ? '0 : cnt + 1'b1;
    thr_next  = THR_W'(duty_quarters(duty_next) * QUARTER);
    en_next   = (state_next == CH_RUN) && ({1'b0, cnt_next} < thr_next);
    pins_next = (state_next == CH_RUN) ? dir_pins(dir_next) : PINS_OFF;
  end

endmodule

// File: rtl/motor_pwm_driver.sv
// Dual H-bridge PWM driver: shared period counter, two channels, L298N pin mapping.
module motor_pwm_driver
  import motor_pwm_pkg::*;
#(
  parameter int PERIOD_CYCLES = 1000,
  parameter int DEAD_PERIODS  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  motor_pwm_driver_if.slave   bus
);

  localparam int CNT_W = $clog2(PERIOD_CYCLES);

  logic [CNT_W-1:0] cnt;
  logic             boundary;
  logic             period_start;
  logic             en_a, en_b, fault_a, fault_b;
  logic [1:0]       pins_a, pins_b;

  assign boundary = (cnt == CNT_W'(PERIOD_CYCLES - 1));

  // Period counter and the registered pulse that marks cnt==0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      period_start <= 1'b0;
    end else begin
      cnt          <= boundary ? '0 : cnt + 1'b1;
      period_start <= boundary;
    end
  end

  pwm_channel #(
    .PERIOD_CYCLES(PERIOD_CYCLES),
    .DEAD_PERIODS (DEAD_PERIODS),
    .CNT_W        (CNT_W)
  ) u_chan_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .cnt      (cnt),
    .boundary (boundary),
    .duty_code(bus.DutyCycleA),
    .fwd      (bus.FWDA),
    .bwd      (bus.BWDA),
    .en       (en_a),
    .pins     (pins_a),
    .fault    (fault_a)
  );

  pwm_channel #(
    .PERIOD_CYCLES(PERIOD_CYCLES),
    .DEAD_PERIODS (DEAD_PERIODS),
    .CNT_W        (CNT_W)
  ) u_chan_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .cnt      (cnt),
    .boundary (boundary),
    .duty_code(bus.DutyCycleB),
    .fwd      (bus.FWDB),
    .bwd      (bus.BWDB),
    .en       (en_b),
    .pins     (pins_b),
    .fault    (fault_b)
  );

  assign bus.ENA         = en_a;
  assign bus.IN1         = pins_a[1];
  assign bus.IN2         = pins_a[0];
  assign bus.FaultA      = fault_a;
  assign bus.ENB         = en_b;
  assign bus.IN3         = pins_b[1];
  assign bus.IN4         = pins_b[0];
  assign bus.FaultB      = fault_b;
  assign bus.PeriodStart = period_start;

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Self-checking bench for motor_pwm_driver with a period-level behavioural model.
module tb_motor_pwm_driver;

  localparam int P  = 8;
  localparam int DP = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  motor_pwm_driver_if bus();

  motor_pwm_driver #(
    .PERIOD_CYCLES(P),
    .DEAD_PERIODS (DP)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model state: phase within the period, active direction (0 none, 1 fwd, 2 bwd),
  // dead periods still to run, latched duty code and fault per motor.
  int mph, seen;
  int act_a, dead_a, code_a, flt_a;
  int act_b, dead_b, code_b, flt_b;
  int ha, hb, sum_en;

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at t=%0t", name, actual, expected, $time);
    end
  endtask

  task automatic apply_stimulus(input logic fa, input logic ba, input logic [1:0] da,
                                input logic fb, input logic bb, input logic [1:0] db);
    bus.FWDA = fa;
    bus.BWDA = ba;
    bus.DutyCycleA = da;
    bus.FWDB = fb;
    bus.BWDB = bb;
    bus.DutyCycleB = db;
  endtask

  function automatic int req_dir(input logic f, input logic b);
    if (f && !b) return 1;
    if (b && !f) return 2;
    return 0;
  endfunction

  function automatic int next_dead(input int act, input int dead, input logic f, input logic b);
    int l;
    l = req_dir(f, b);
    if (dead > 0) return dead - 1;
    if (act != 0 && l != 0 && l != act) return DP;
    return 0;
  endfunction

  function automatic int next_act(input int act, input int dead, input logic f, input logic b);
    int l;
    l = req_dir(f, b);
    if (dead > 0) return (dead == 1) ? l : 0;
    if (act != 0 && l != 0 && l != act) return 0;
    return l;
  endfunction

  // Model advances once per cycle and re-plans each motor at every period boundary.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mph <= 0; seen <= 0;
      act_a <= 0; dead_a <= 0; code_a <= 0; flt_a <= 0;
      act_b <= 0; dead_b <= 0; code_b <= 0; flt_b <= 0;
    end else if (mph == P - 1) begin
      mph    <= 0;
      seen   <= 1;
      act_a  <= next_act(act_a, dead_a, bus.FWDA, bus.BWDA);
      dead_a <= next_dead(act_a, dead_a, bus.FWDA, bus.BWDA);
      code_a <= int'(bus.DutyCycleA);
      flt_a  <= int'(bus.FWDA & bus.BWDA);
      act_b  <= next_act(act_b, dead_b, bus.FWDB, bus.BWDB);
      dead_b <= next_dead(act_b, dead_b, bus.FWDB, bus.BWDB);
      code_b <= int'(bus.DutyCycleB);
      flt_b  <= int'(bus.FWDB & bus.BWDB);
    end else begin
      mph <= mph + 1;
    end
  end

  // Every-cycle comparison of all outputs against the model, away from the active edge.
  always @(negedge clk) begin
    check_output("model_ENA", int'(bus.ENA), int'(act_a != 0 && mph < (code_a + 1) * P / 4));
    check_output("model_IN1", int'(bus.IN1), int'(act_a == 1));
    check_output("model_IN2", int'(bus.IN2), int'(act_a == 2));
    check_output("model_FaultA", int'(bus.FaultA), flt_a);
    check_output("model_ENB", int'(bus.ENB), int'(act_b != 0 && mph < (code_b + 1) * P / 4));
    check_output("model_IN3", int'(bus.IN3), int'(act_b == 1));
    check_output("model_IN4", int'(bus.IN4), int'(act_b == 2));
    check_output("model_FaultB", int'(bus.FaultB), flt_b);
    check_output("model_PeriodStart", int'(bus.PeriodStart), int'(seen != 0 && mph == 0));
  end

  // Counts enable high cycles over one full period starting at the next PeriodStart.
  task automatic measure(output int hi_a, output int hi_b);
    int guard;
    guard = 0;
    while (!bus.PeriodStart && guard < 3 * P) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 3 * P) check_output("period_start_timeout", int'(bus.PeriodStart), 1);
    hi_a = 0;
    hi_b = 0;
    for (int i = 0; i < P; i++) begin
      hi_a += int'(bus.ENA);
      hi_b += int'(bus.ENB);
      @(negedge clk);
    end
  endtask

  initial begin
    apply_stimulus(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_output("reset_ENA", int'(bus.ENA), 0);
    check_output("reset_IN1", int'(bus.IN1), 0);
    check_output("reset_PeriodStart", int'(bus.PeriodStart), 0);
    check_output("reset_FaultA", int'(bus.FaultA), 0);
    rst_n = 1'b1;

    // Motor A forward at 50%.
    apply_stimulus(1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 2'b00);
    measure(ha, hb);
    check_output("fwd50_ENA_high", ha, 4);
    check_output("fwd50_ENB_high", hb, 0);
    check_output("fwd50_IN1", int'(bus.IN1), 1);
    check_output("fwd50_IN2", int'(bus.IN2), 0);

    // Duty sweep on motor B; each change appears one period later.
    for (int code = 0; code < 4; code++) begin
      apply_stimulus(1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 2'(code));
      measure(ha, hb);
      check_output("sweep_b_old_period", hb, (code == 0) ? 0 : 2 * code);
      measure(ha, hb);
      check_output("sweep_b_new_period", hb, 2 * (code + 1));
    end

    // Mid-period reversal of A to backward.
    repeat (3) @(negedge clk);
    apply_stimulus(1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 2'b11);
    measure(ha, hb);
    check_output("rev_dead1_ENA", ha, 0);
    check_output("rev_dead1_ENB", hb, 8);
    measure(ha, hb);
    check_output("rev_dead2_ENA", ha, 0);
    check_output("rev_bwd_IN1", int'(bus.IN1), 0);
    check_output("rev_bwd_IN2", int'(bus.IN2), 1);
    measure(ha, hb);
    check_output("rev_bwd_ENA", ha, 4);

    // Invalid command on A, then recovery to forward.
    apply_stimulus(1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 2'b11);
    measure(ha, hb);
    check_output("fault_prev_ENA", ha, 4);
    check_output("fault_FaultA", int'(bus.FaultA), 1);
    check_output("fault_IN2", int'(bus.IN2), 0);
    apply_stimulus(1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 2'b11);
    measure(ha, hb);
    check_output("fault_period_ENA", ha, 0);
    check_output("fault_cleared", int'(bus.FaultA), 0);
    check_output("fault_resume_IN1", int'(bus.IN1), 1);
    measure(ha, hb);
    check_output("fault_resume_ENA", ha, 4);

    // Both motors reverse together while the duty codes change during DEAD.
    apply_stimulus(1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 2'b11);
    measure(ha, hb);
    check_output("dual_prev_ENA", ha, 4);
    check_output("dual_prev_ENB", hb, 8);
    apply_stimulus(1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 2'b00);
    measure(ha, hb);
    check_output("dual_dead1_EN", ha + hb, 0);
    apply_stimulus(1'b0, 1'b1, 2'b11, 1'b0, 1'b1, 2'b01);
    measure(ha, hb);
    check_output("dual_dead2_EN", ha + hb, 0);
    check_output("dual_IN2", int'(bus.IN2), 1);
    check_output("dual_IN4", int'(bus.IN4), 1);
    measure(ha, hb);
    check_output("dual_resume_ENA", ha, 8);
    check_output("dual_resume_ENB", hb, 4);

    // Reverse A again, then reset in the middle of DEAD (A) and a pulse (B).
    apply_stimulus(1'b1, 1'b0, 2'b11, 1'b0, 1'b1, 2'b01);
    measure(ha, hb);
    check_output("rst_prev_ENA", ha, 8);
    repeat (2) @(negedge clk);
    check_output("pre_reset_ENB", int'(bus.ENB), 1);
    check_output("pre_reset_ENA", int'(bus.ENA), 0);
    #2 rst_n = 1'b0;
    #1;
    check_output("async_ENB", int'(bus.ENB), 0);
    check_output("async_IN4", int'(bus.IN4), 0);
    check_output("async_ENA", int'(bus.ENA), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    sum_en = 0;
    for (int i = 0; i < P; i++) begin
      sum_en += int'(bus.ENA) + int'(bus.ENB);
      @(negedge clk);
    end
    check_output("post_reset_no_pulse", sum_en, 0);
    measure(ha, hb);
    check_output("post_reset_ENA", ha, 8);
    check_output("post_reset_ENB", hb, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/motor_pwm_driver.md
# motor_pwm_driver

Downstream stage of the drive-train direction-control FSMs. Consumes per-motor 2-bit duty codes and FWD/BWD direction bits, and produces glitch-free PWM enable plus direction pins for the dual H-bridge (L298N-style: ENA/IN1/IN2 for motor A, ENB/IN3/IN4 for motor B). Commands are latched only at PWM period boundaries. A reversal always inserts a dead interval so neither bridge leg sees an instantaneous polarity flip.

## Interface
- PERIOD_CYCLES, 1000, clk cycles per PWM period; multiple of 4, ≥ 8
- DEAD_PERIODS, 2, whole PWM periods of forced-off time on a direction reversal; ≥ 1
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- DutyCycleA, DutyCycleB  in  2  duty code: 00=25%, 01=50%, 10=75%, 11=100%
- FWDA, BWDA, FWDB, BWDB  in  1  direction request per motor; both 0 = off; both 1 = invalid
- ENA, ENB  out  1  PWM enable to the bridge
- IN1, IN2  out  1  motor A polarity: FWD=10, BWD=01, off/dead=00
- IN3, IN4  out  1  motor B polarity, same encoding as IN1/IN2
- PeriodStart  out  1  one-cycle pulse at the first cycle of each period
- FaultA, FaultB  out  1  high while the latched command for that motor is invalid (FWD&BWD)

## Operation
- Shared period counter `cnt` runs 0..PERIOD_CYCLES-1 and wraps. The boundary is `cnt == PERIOD_CYCLES-1`.
- At each boundary, each channel latches its duty code and decodes direction into dir ∈ {NONE, FWD, BWD}. Invalid decodes to NONE and sets Fault.
- Threshold is `(code+1)*PERIOD_CYCLES/4`. The width is clog2(PERIOD_CYCLES)+1 bits, so 100% has no overflow.
- Channel FSM (per motor):
  - OFF: EN=0, IN=00.
    - Latched dir FWD/BWD → RUN with that dir.
    - NONE → stay in OFF.
  - RUN: IN = dir pins, EN = (cnt < threshold).
    - Latched dir same as current → RUN with the new duty.
    - Latched NONE → OFF, with no dead time.
    - Latched opposite dir → DEAD with dead_cnt = DEAD_PERIODS.
  - DEAD: EN=0, IN=00. dead_cnt decrements at each boundary. The pending command is re-latched at every boundary.
    - When dead_cnt reaches 0 at a boundary → RUN with the pending dir, or OFF if the pending dir is NONE.
- The 100% code holds EN high for the whole period. The 25% code holds EN high for the first PERIOD_CYCLES/4 cycles.
- Input changes between boundaries are ignored, so no mid-period glitches can occur.

## Timing
- All outputs are registered. On reset: ENA=ENB=0, IN1..IN4=0, PeriodStart=0, FaultA=FaultB=0, cnt=0, both FSMs OFF, dead_cnt=0.
- Reset is asynchronous on assertion. After deassertion, the first boundary is at cnt=PERIOD_CYCLES-1.
- Inputs sampled at the boundary cycle take effect on the outputs in the following cycle, when cnt=0 and PeriodStart=1. Worst-case command latency is PERIOD_CYCLES+1 cycles.
- EN is compared against the cnt value of the same cycle and registered, so the EN high-time per period is exactly the threshold.
- PeriodStart is high when cnt==0 is presented.
- Reversal: outputs are 00/EN=0 for exactly DEAD_PERIODS full periods, then the new polarity starts at a period start.
- A reversal back to the original dir during DEAD still completes the full DEAD interval.
- Fault tracks the latched command: it updates at boundaries only and clears at the first boundary that latches a valid command.
- Channels A and B are independent. Simultaneous reversal on both channels runs both DEAD counters in parallel.
- Reset mid-DEAD or mid-period forces OFF immediately. No partial pulse follows deassertion.

## Structure
- Package `motor_pwm_pkg` holds:
  - the direction enum {DIR_NONE, DIR_FWD, DIR_BWD};
  - the channel state enum {CH_OFF, CH_RUN, CH_DEAD};
  - the duty-code constants;
  - the IN-pin encodings.
- Sub-module `pwm_channel` (instantiated twice) holds the latch, FSM, dead counter, threshold and EN compare. It takes `cnt` and the boundary strobe as inputs.
- The top level owns the period counter, PeriodStart, and the pin mapping.

## Test plan
Scenarios use PERIOD_CYCLES=8 and DEAD_PERIODS=2.
- Reset, then FWDA=1 with DutyCycleA=01 → from the first period start: IN1/IN2=10, ENA high for 4 of 8 cycles each period. Motor B stays 00/0.
- Sweep DutyCycleB through 00, 01, 10, 11 with FWDB=1 → ENB high-time of 2, 4, 6, 8 cycles per period. The change lands only at a period start.
- RUN FWD on A, switch to BWDA=1 mid-period → current period finishes, then 2 full periods of IN=00/ENA=0, then IN1/IN2=01 from the next period start.
- FWDA=BWDA=1 at a boundary → FaultA=1, IN=00, ENA=0. Restoring FWDA-only clears FaultA and resumes RUN at the next period start.
- Both motors reverse simultaneously while toggling duty during DEAD → both DEAD for exactly 2 periods, then both resume with the last-latched duty.
- Assert rst_n=0 mid-DEAD and mid-pulse → all outputs 0 asynchronously. After release there is no EN until the first full period with a valid command.
